bram_port_arbiter: RTL

Burst-capable, round-robin arbiter that shares one port of `dual_port_bram` between two requesters (masters 0 and 1). It sequences single-word or incrementing-address bursts onto the BRAM port, steers write data in and read data back, and accounts for the BRAM's one-cycle read latency. One instance sits in front of each BRAM port that needs sharing; the other BRAM port stays free for a dedicated client.

---
 rtl/bram_port_arbiter_pkg.sv | 17 +
 rtl/bram_rr_select.sv | 20 ++
 rtl/bram_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the two-master BRAM port arbiter.
package bram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int LEN_WIDTH_DEF = 8;

  // Master indices; also the encoding used for the owner/last registers.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/bram_rr_select.sv
// Two-way round-robin pick: lone requester wins, ties go to the master
// that did not win last time. Purely combinational.
module bram_rr_select
  import bram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       vld
);

  // One-hot winner; a tie is broken away from the previous winner.
  always_comb begin
    win = req;
    if (&req) win = (last == M1) ? 2'b01 : 2'b10;
  end

  assign vld = |req;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two masters with incrementing-address bursts.
// All port-side controls decode registered state only, so nothing from
// mn_req reaches the BRAM combinationally.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [LEN_WIDTH-1:0]  m0_len,
  input  logic [DATA_WIDTH-1:0] m0_din,
  output logic                  m0_din_ack,
  output logic [DATA_WIDTH-1:0] m0_dout,
  output logic                  m0_dout_stb,
  output logic                  m0_grant,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [LEN_WIDTH-1:0]  m1_len,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m1_din_ack,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  m1_dout_stb,
  output logic                  m1_grant,
  output logic                  m1_done,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  arb_state_e            state, state_nxt;
  logic                  cur_wr;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  owner;
  logic                  last;
  logic                  rd_stb_q;

  logic [1:0]            win;
  logic                  win_vld;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  in_burst;
  logic                  busy;

  bram_rr_select u_sel (
    .req  ({m1_req, m0_req}),
    .last (last),
    .win  (win),
    .vld  (win_vld)
  );

  // One-hot AND-OR mux of the winner's request fields.
  assign sel_wr   = (win[0] & m0_wr) | (win[1] & m1_wr);
  assign sel_addr = ({ADDR_WIDTH{win[0]}} & m0_addr) | ({ADDR_WIDTH{win[1]}} & m1_addr);
  assign sel_len  = ({LEN_WIDTH{win[0]}} & m0_len) | ({LEN_WIDTH{win[1]}} & m1_len);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; a zero-length burst skips straight to the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (win_vld) state_nxt = (sel_len == '0) ? ST_DONE : ST_BURST;
      ST_BURST: if (remaining == LEN_WIDTH'(1)) state_nxt = cur_wr ? ST_DONE : ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's burst at grant, then step address/count per access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      owner     <= M0;
      last      <= M1;
    end else if (state == ST_IDLE && win_vld) begin
      cur_wr    <= sel_wr;
      cur_addr  <= sel_addr;
      remaining <= sel_len;
      owner     <= win[1];
      last      <= win[1];
    end else if (state == ST_BURST) begin
      cur_addr  <= cur_addr + ADDR_WIDTH'(1);
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  // Read strobe trails each read access by one cycle to match BRAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_stb_q <= 1'b0;
    else        rd_stb_q <= (state == ST_BURST) && !cur_wr;
  end

  assign in_burst  = (state == ST_BURST);
  assign busy      = (state != ST_IDLE);

  assign bram_wr   = in_burst && cur_wr;
  assign bram_addr = in_burst ? cur_addr : '0;
  assign bram_din  = (owner == M1) ? m1_din : m0_din;

  assign m0_grant    = busy && (owner == M0);
  assign m1_grant    = busy && (owner == M1);
  assign m0_din_ack  = bram_wr && (owner == M0);
  assign m1_din_ack  = bram_wr && (owner == M1);
  assign m0_dout_stb = rd_stb_q && (owner == M0);
  assign m1_dout_stb = rd_stb_q && (owner == M1);
  assign m0_done     = (state == ST_DONE) && (owner == M0);
  assign m1_done     = (state == ST_DONE) && (owner == M1);

  // Read data fans out to both; only the owner's strobe qualifies it.
  assign m0_dout = bram_dout;
  assign m1_dout = bram_dout;

endmodule
